// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and long-latency results onto one register-file write port (clk, rst, pipe_*, lu_*, we/waddr/wdata, stall_req, qaddr*/busy*)
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_wreg,
  input  logic [AW-1:0] pipe_wd,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_wd,
  input  logic [DW-1:0] lu_wdata,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          stall_req,
  input  logic [AW-1:0] qaddr1,
  input  logic [AW-1:0] qaddr2,
  output logic          busy1,
  output logic          busy2
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic we_q, we_d, stall_q, stall_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic pipe_act, acc, enq, pop;
  always_comb begin
    pipe_act = pipe_wreg && pipe_wd != '0;
    lu_ready = !rst && count_q < FULL;
    acc = lu_valid && lu_ready;
    enq = acc && lu_wd != '0;
    pop = !pipe_act && count_q != '0;
    valid_d = valid_q;
    addr_d = addr_q;
    data_d = data_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy1 = busy1 | (valid_q[i] && addr_q[i] == qaddr1);
      busy2 = busy2 | (valid_q[i] && addr_q[i] == qaddr2);
      if (pipe_act && addr_q[i] == pipe_wd) valid_d[i] = 1'b0;
    end
    busy1 = busy1 && !rst && qaddr1 != '0;
    busy2 = busy2 && !rst && qaddr2 != '0;
    if (pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d = rptr_q + 1'b1;
    end
    // a same-cycle pipe write to the same register is younger, so the entry is born dead
    if (enq) begin
      valid_d[wptr_q] = !(pipe_act && lu_wd == pipe_wd);
      addr_d[wptr_q] = lu_wd;
      data_d[wptr_q] = lu_wdata;
      wptr_d = wptr_q + 1'b1;
    end
    count_d = count_q + (PW+1)'(enq) - (PW+1)'(pop);
    we_d = pipe_act || (pop && valid_q[rptr_q]);
    waddr_d = pipe_act ? pipe_wd : pop ? addr_q[rptr_q] : '0;
    wdata_d = pipe_act ? pipe_wdata : pop ? data_q[rptr_q] : '0;
    starve_d = (pop || count_q == '0) ? '0 : (starve_q == LIM) ? starve_q : starve_q + 1'b1;
    stall_d = starve_d >= LIM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      starve_q <= '0;
      stall_q <= 1'b0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      starve_q <= starve_d;
      stall_q <= stall_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
    addr_q <= addr_d;
    data_q <= data_d;
  end
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign stall_req = stall_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic pipe_wreg = 1'b0, lu_valid = 1'b0;
  logic [4:0] pipe_wd = '0, lu_wd = '0, qaddr1 = '0, qaddr2 = '0;
  logic [31:0] pipe_wdata = '0, lu_wdata = '0;
  logic lu_ready, we, stall_req, busy1, busy2;
  logic [4:0] waddr;
  logic [31:0] wdata;
  int n_chk = 0, n_fail = 0, nxt;
  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst), .pipe_wreg(pipe_wreg), .pipe_wd(pipe_wd), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wd(lu_wd), .lu_wdata(lu_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .stall_req(stall_req),
    .qaddr1(qaddr1), .qaddr2(qaddr2), .busy1(busy1), .busy2(busy2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct { bit v; bit [4:0] a; bit [31:0] d; } ent_t;
  ent_t q[$];
  int s = 0, n;
  bit chk_en = 0, e_we = 0, e_stall = 0, e_ad = 1, pa, pp, mb1, mb2;
  bit [4:0] e_waddr = '0;
  bit [31:0] e_wdata = '0;
  ent_t h;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_we", we, e_we);
      chk("m_stall", stall_req, e_stall);
      if (e_ad) begin
        chk("m_waddr", waddr, e_waddr);
        chk("m_wdata", wdata, e_wdata);
      end
    end
    mb1 = 0;
    mb2 = 0;
    foreach (q[i]) begin
      mb1 |= q[i].v && q[i].a == qaddr1;
      mb2 |= q[i].v && q[i].a == qaddr2;
    end
    chk("m_lu_ready", lu_ready, !rst && q.size() < DEPTH);
    chk("m_busy1", busy1, !rst && qaddr1 != 0 && mb1);
    chk("m_busy2", busy2, !rst && qaddr2 != 0 && mb2);
    if (rst) begin
      q.delete();
      s = 0;
      {e_we, e_stall, e_waddr, e_wdata, e_ad} = {3'b000, 5'd0, 32'd0, 1'b1};
    end else begin
      n = q.size();
      pa = pipe_wreg && pipe_wd != 0;
      pp = !pa && n > 0;
      e_ad = 1;
      if (pa) {e_we, e_waddr, e_wdata} = {1'b1, pipe_wd, pipe_wdata};
      else if (pp) begin
        h = q.pop_front();
        {e_we, e_waddr, e_wdata, e_ad} = {h.v, h.a, h.d, h.v};
      end else {e_we, e_waddr, e_wdata} = '0;
      foreach (q[i]) if (pa && q[i].a == pipe_wd) q[i].v = 0;
      if (lu_valid && n < DEPTH && lu_wd != 0)
        q.push_back('{v: !(pa && lu_wd == pipe_wd), a: lu_wd, d: lu_wdata});
      s = (n == 0 || pp) ? 0 : (s < LIM ? s + 1 : LIM);
      e_stall = s >= LIM;
    end
    chk_en = 1;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {pipe_wreg, lu_valid, pipe_wd, lu_wd, pipe_wdata, lu_wdata} = '0;
  endtask
  task automatic collect();
    if (we) begin
      chk("wrap_addr", waddr, 5'(nxt));
      chk("wrap_data", wdata, 32'(nxt) * 32'h01010101);
      nxt++;
    end
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst_we", we, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_lu_ready", lu_ready, 0);
    rst = 0;
    {pipe_wreg, pipe_wd, pipe_wdata} = {1'b1, 5'd5, 32'h1234};
    cyc();
    chk("pipe_we", we, 1);
    chk("pipe_waddr", waddr, 5);
    chk("pipe_wdata", wdata, 32'h1234);
    pipe_wd = 0;
    cyc();
    chk("pipe_r0_we", we, 0);
    idle();
    {lu_valid, lu_wd, lu_wdata, qaddr1} = {1'b1, 5'd7, 32'hA5A5, 5'd7};
    cyc();
    chk("drain_busy", busy1, 1);
    lu_valid = 0;
    cyc();
    chk("drain_we", we, 1);
    chk("drain_waddr", waddr, 7);
    chk("drain_wdata", wdata, 32'hA5A5);
    chk("drain_busy_clr", busy1, 0);
    {pipe_wreg, pipe_wd, pipe_wdata, lu_valid, lu_wd, lu_wdata} = {1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88};
    cyc();
    {lu_wd, lu_wdata} = {5'd9, 32'h99};
    cyc();
    {lu_wd, lu_wdata} = {5'd10, 32'hAA};
    repeat (4) cyc();
    chk("full_ready", lu_ready, 0);
    chk("full_stall", stall_req, 1);
    pipe_wreg = 0;
    cyc();
    chk("bp_r8", waddr, 8);
    cyc();
    chk("bp_r9", waddr, 9);
    lu_valid = 0;
    cyc();
    chk("bp_r10", waddr, 10);
    chk("bp_r10_we", we, 1);
    {pipe_wreg, pipe_wd, pipe_wdata, lu_valid, lu_wd, lu_wdata} = {1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h11};
    cyc();
    {pipe_wd, pipe_wdata, lu_valid, qaddr1, qaddr2} = {5'd4, 32'h22, 1'b0, 5'd4, 5'd6};
    cyc();
    chk("kill_waddr", waddr, 4);
    chk("kill_wdata", wdata, 32'h22);
    chk("kill_busy", busy1, 0);
    {pipe_wd, pipe_wdata, lu_valid, lu_wd, lu_wdata} = {5'd6, 32'h66, 1'b1, 5'd6, 32'h77};
    cyc();
    chk("kill6_wdata", wdata, 32'h66);
    chk("kill6_busy", busy2, 0);
    idle();
    cyc();
    chk("kill_drain4_we", we, 0);
    cyc();
    chk("kill_drain6_we", we, 0);
    {pipe_wreg, pipe_wd, pipe_wdata, lu_valid, lu_wd, lu_wdata} = {1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88};
    cyc();
    {lu_wd, lu_wdata} = {5'd9, 32'h99};
    cyc();
    lu_valid = 0;
    repeat (4) cyc();
    chk("rmid_stall_pre", stall_req, 1);
    idle();
    rst = 1;
    cyc();
    chk("rmid_we", we, 0);
    chk("rmid_stall", stall_req, 0);
    rst = 0;
    cyc();
    chk("rmid_ready", lu_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rmid_no_write", we, 0);
    end
    nxt = 1;
    for (int i = 1; i <= 10; i++) begin
      {lu_valid, lu_wd, lu_wdata} = {1'b1, 5'(i), 32'(i) * 32'h01010101};
      cyc();
      collect();
    end
    lu_valid = 0;
    repeat (4) begin
      cyc();
      collect();
    end
    chk("wrap_count", nxt, 11);
    for (int i = 0; i < 800; i++) begin
      rst = $urandom_range(0, 39) == 0;
      pipe_wreg = $urandom_range(0, 9) < 4;
      pipe_wd = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      lu_valid = $urandom_range(0, 1) == 1;
      lu_wd = 5'($urandom_range(0, 7));
      lu_wdata = $urandom;
      qaddr1 = 5'($urandom_range(0, 7));
      qaddr2 = 5'($urandom_range(0, 7));
      cyc();
    end
    idle();
    rst = 0;
    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: long-latency result buffer entries, power of two, at least 2.
REQ-002 Parameter STARVE_LIM, default 4: consecutive non-draining cycles before stall_req is raised.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1), sampled on posedge clk.
REQ-005 pipe_wreg  in  1  pipeline-channel write request; no backpressure, never dropped.
REQ-006 pipe_wd  in  `RegAddrBus  pipeline destination register.
REQ-007 pipe_wdata  in  `RegBus  pipeline result.
REQ-008 lu_valid  in  1  long-latency unit result valid.
REQ-009 lu_ready  out  1  buffer can accept a result.
REQ-010 lu_wd  in  `RegAddrBus  long-latency destination register.
REQ-011 lu_wdata  in  `RegBus  long-latency result.
REQ-012 we  out  1  register-file write enable (`WriteEnable = 1'b1).
REQ-013 waddr  out  `RegAddrBus  register-file write address.
REQ-014 wdata  out  `RegBus  register-file write data.
REQ-015 stall_req  out  1  request to freeze the pipeline so buffered results can drain.
REQ-016 qaddr1, qaddr2  in  `RegAddrBus  decode-stage pending-write queries.
REQ-017 busy1, busy2  out  1  the queried register has a live buffered write.

Function
REQ-018 The module SHALL hold a DEPTH-entry FIFO; each entry has valid, addr and data fields; count ranges from 0 to DEPTH.
REQ-019 lu_ready SHALL be (count < DEPTH), combinational from registered state.
REQ-020 Accept SHALL be lu_valid && lu_ready; an accepted result with lu_wd == 0 SHALL be consumed and discarded, without being enqueued.
REQ-021 we/waddr/wdata SHALL be registered and SHALL update at every edge with the first matching priority below.
- Priority 1: if pipe_wreg and pipe_wd != 0, output the pipe write.
- Priority 2: otherwise, if count > 0, pop the head; output it with we = head.valid.
- Otherwise: we = 0, waddr = 0, wdata = `ZeroWord.
REQ-022 pipe_wreg with pipe_wd == 0 SHALL be treated as idle.
REQ-023 An entry enqueued at edge N SHALL be eligible to drain no earlier than edge N+1, giving a minimum lu-to-we latency of 2 edges.
REQ-024 Enqueue and pop in the same edge SHALL both occur; count is unchanged.
REQ-025 A pipe write with pipe_wd != 0 SHALL clear the valid bit of every stored entry whose addr equals pipe_wd; the pipe write is younger and must not be overwritten.
REQ-026 A result accepted in the same cycle as a pipe write to the same nonzero register SHALL be enqueued with valid = 0.
REQ-027 A popped entry with valid = 0 SHALL count as a drain, with we = 0 at the output.
REQ-028 starve_cnt SHALL reset to 0 on any pop or when count == 0, and SHALL otherwise increment, saturating at STARVE_LIM.
REQ-029 stall_req SHALL be registered and equal to (next starve_cnt >= STARVE_LIM).
REQ-030 A pipe write arriving while stall_req is high SHALL still win priority; no data is lost.
REQ-031 busyN SHALL be 1 when qaddrN != 0 and any stored entry is valid with addr == qaddrN; otherwise 0. busyN is combinational.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 While rst is sampled high, the following SHALL hold at the edge.
- we = 0, waddr = 0, wdata = `ZeroWord.
- count = 0, pointers = 0, all valid bits = 0.
- starve_cnt = 0, stall_req = 0.
REQ-034 During rst, lu_ready and busy1/busy2 SHALL be forced to 0 combinationally.
REQ-035 Reset mid-operation SHALL discard all buffered results.
REQ-036 The first edge after rst deasserts SHALL behave as a normal cycle.

Verification
REQ-037 Pipe-only test: pipe_wreg=1, pipe_wd=5, pipe_wdata=32'h1234 -> the next edge gives we=1, waddr=5, wdata=32'h1234; pipe_wd=0 -> we=0.
REQ-038 LU drain test: pipe idle, lu_valid=1, lu_wd=7, lu_wdata=32'hA5A5 for 1 cycle -> busy for qaddr1=7 goes high after edge 1; we=1, waddr=7 at edge 2; busy1 clears.
REQ-039 Full/backpressure test: pipe continuously writing r3, three lu results to r8, r9, r10 offered -> two accepted, lu_ready=0; stall_req=1 after 4 non-draining cycles; drop pipe_wreg -> r8 then r9 written on consecutive edges, lu_ready returns, r10 accepted.
REQ-040 Kill test: buffer holds {r4, 32'h11}; pipe writes r4=32'h22 -> output r4=32'h22; at the later drain, we=0, so r4 keeps 32'h22; a simultaneous lu r6 plus pipe r6 -> only the pipe value is written.
REQ-041 Reset-mid-op test: two entries buffered and stall_req=1, rst pulsed 1 cycle -> count=0, stall_req=0, we=0; no buffered write ever appears.
REQ-042 Wrap test: 10 back-to-back lu results to r1..r10 with pipe idle -> written in order r1..r10 with correct data, as a directed pointer-wrap case.
